// File: rtl/sntc_ldpc_cword_serializer.sv
// Holds one encoded LDPC codeword and streams it as W-bit beats on a valid/ready bus.
// Optional trailer beat (XOR of all data beats) when SNTC_SER_PARITY_EN is defined.
module sntc_ldpc_cword_serializer #(
   parameter int NN = 'h000d0,
   parameter int W  = 8
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          clr,
   input  logic [NN-1:0] cword_in,
   input  logic          cword_ok,
   input  logic          cword_load,
   output logic          cword_ready,
   output logic [W-1:0]  out_data,
   output logic          out_valid,
   input  logic          out_ready,
   output logic          out_sop,
   output logic          out_eop,
   output logic          out_bad,
   output logic [15:0]   frame_cnt
);

   localparam int NBEAT = (NN + W - 1) / W;
   localparam int CNT_W = $clog2(NBEAT + 1);
   localparam int HW    = NBEAT * W;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_SEND  = 2'd1;
`ifdef SNTC_SER_PARITY_EN
   localparam logic [1:0] S_TRAIL = 2'd2;
`endif

   logic [1:0]       state;
   logic [CNT_W-1:0] cnt;
   logic [HW-1:0]    hold;
   logic [HW-1:0]    cword_pad;
   logic             bad;
   logic             last_data;
   logic             final_beat;
   logic             load_hs;
   logic             out_hs;
   logic [W-1:0]     beat;

   // Pad to a whole number of beats so bits beyond NN read back as zero.
   always_comb begin
      cword_pad           = '0;
      cword_pad[NN-1:0]   = cword_in;
   end

   assign last_data = (cnt == CNT_W'(NBEAT - 1));
   assign beat      = hold[int'(cnt) * W +: W];

`ifdef SNTC_SER_PARITY_EN
   logic [W-1:0] trailer;

   always_comb begin
      trailer = '0;
      for (int k = 0; k < NBEAT; k++) begin
         trailer = trailer ^ hold[k * W +: W];
      end
   end

   assign final_beat = (state == S_TRAIL);
`else
   assign final_beat = (state == S_SEND) && last_data;
`endif

   assign out_valid   = (state != S_IDLE);
   assign out_sop     = (state == S_SEND) && (cnt == '0);
   assign out_eop     = final_beat;
   assign out_bad     = out_valid & bad;
   assign cword_ready = (state == S_IDLE) | (final_beat & out_ready);
   assign load_hs     = cword_load & cword_ready;
   assign out_hs      = out_valid & out_ready;

   always_comb begin
      out_data = '0;
      if (state == S_SEND) begin
         out_data = beat;
      end
`ifdef SNTC_SER_PARITY_EN
      else if (state == S_TRAIL) begin
         out_data = trailer;
      end
`endif
   end

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         state     <= S_IDLE;
         cnt       <= '0;
         hold      <= '0;
         bad       <= 1'b0;
         frame_cnt <= '0;
      end else begin
         if (out_hs && final_beat) begin
            frame_cnt <= frame_cnt + 16'd1;
         end
         // A load on the final-beat handshake restarts at beat 0 with no idle gap.
         if (load_hs) begin
            hold  <= cword_pad;
            bad   <= ~cword_ok;
            state <= S_SEND;
            cnt   <= '0;
         end else if (out_hs) begin
            if ((state == S_SEND) && !last_data) begin
               cnt <= cnt + 1'b1;
            end else if (final_beat) begin
               state <= S_IDLE;
               cnt   <= '0;
            end
`ifdef SNTC_SER_PARITY_EN
            else if (state == S_SEND) begin
               state <= S_TRAIL;
            end
`endif
         end
      end
   end

endmodule
